// File: rtl/router_vc_fifo_if.sv
// router_vc_fifo_if
//   Handshake bundle between the ingress links / egress stage and router_vc_fifo.
//   slave  : the FIFO side (takes enq/d_in/deq/clr, drives status and head word)
//   master : the producer/consumer side
//   Signals
//     clr      synchronous clear of all channels
//     d_in     packed write data, channel c at [c*V_P1WIDTH +: V_P1WIDTH]
//     enq      per-channel enqueue strobe
//     full_n   per-channel not-full
//     afull    per-channel almost-full
//     ovf      per-channel sticky overflow
//     d_out    head word of the granted channel
//     ch_out   index of the granted channel
//     empty_n  at least one channel holds data
//     deq      pop the granted head
interface router_vc_fifo_if #(
    parameter int V_P1WIDTH = 8,
    parameter int V_NCH     = 4,
    parameter int V_CHW     = 2
);
    logic                        clr;
    logic [V_NCH*V_P1WIDTH-1:0]  d_in;
    logic [V_NCH-1:0]            enq;
    logic [V_NCH-1:0]            full_n;
    logic [V_NCH-1:0]            afull;
    logic [V_NCH-1:0]            ovf;
    logic [V_P1WIDTH-1:0]        d_out;
    logic [V_CHW-1:0]            ch_out;
    logic                        empty_n;
    logic                        deq;

    modport slave (
        input  clr, d_in, enq, deq,
        output full_n, afull, ovf, d_out, ch_out, empty_n
    );

    modport master (
        output clr, d_in, enq, deq,
        input  full_n, afull, ovf, d_out, ch_out, empty_n
    );
endinterface

// File: rtl/router_vc_fifo.sv
// router_vc_fifo
//   V_NCH independent circular FIFOs of V_P2DEPTH entries each, merged onto one
//   output by a round-robin arbiter. The arbiter pointer only advances on a
//   successful dequeue, to the channel after the one just served.
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    router_vc_fifo_if.slave (enqueue/dequeue handshake and status)
module router_vc_fifo #(
    parameter int V_P1WIDTH      = 8,
    parameter int V_P2DEPTH      = 4,
    parameter int V_P3CNTR_WIDTH = 2,
    parameter int V_NCH          = 4,
    parameter int V_CHW          = 2,
    parameter int V_AFULL_THRESH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    router_vc_fifo_if.slave   bus
);
    localparam int CNTW = V_P3CNTR_WIDTH + 1;

    logic [V_P1WIDTH-1:0]      mem     [V_NCH][V_P2DEPTH];
    logic [V_P3CNTR_WIDTH-1:0] wr_ptr  [V_NCH];
    logic [V_P3CNTR_WIDTH-1:0] rd_ptr  [V_NCH];
    logic [CNTW-1:0]           count   [V_NCH];
    logic [V_CHW-1:0]          rr_ptr;
    logic [V_NCH-1:0]          ovf;

    logic [V_NCH-1:0]          full_n;
    logic [V_NCH-1:0]          afull;
    logic [V_NCH-1:0]          not_empty;
    logic [V_CHW-1:0]          grant;
    logic                      any;
    logic                      deq_ok;

    always_comb begin
        for (int c = 0; c < V_NCH; c++) begin
            full_n[c]    = (count[c] != CNTW'(V_P2DEPTH));
            afull[c]     = (count[c] >= CNTW'(V_AFULL_THRESH));
            not_empty[c] = (count[c] != '0);
        end
    end

    // Cyclic scan starting at rr_ptr; the sum is one bit wider so the wrap
    // also works when V_NCH is not a power of two.
    always_comb begin
        logic [V_CHW:0] idx;
        grant = '0;
        any   = 1'b0;
        for (int i = 0; i < V_NCH; i++) begin
            idx = {1'b0, rr_ptr} + (V_CHW+1)'(i);
            if (idx >= (V_CHW+1)'(V_NCH))
                idx = idx - (V_CHW+1)'(V_NCH);
            if (!any && not_empty[idx[V_CHW-1:0]]) begin
                grant = idx[V_CHW-1:0];
                any   = 1'b1;
            end
        end
    end

    assign deq_ok = bus.deq && any;

    assign bus.full_n  = full_n;
    assign bus.afull   = afull;
    assign bus.ovf     = ovf;
    assign bus.empty_n = any;
    assign bus.ch_out  = any ? grant : '0;
    assign bus.d_out   = any ? mem[grant][rd_ptr[grant]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < V_NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            rr_ptr <= '0;
            ovf    <= '0;
        end else if (bus.clr) begin
            for (int c = 0; c < V_NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            rr_ptr <= '0;
            ovf    <= '0;
        end else begin
            for (int c = 0; c < V_NCH; c++) begin
                logic do_enq;
                logic do_deq;
                do_enq = bus.enq[c] && full_n[c];
                do_deq = deq_ok && (grant == V_CHW'(c));
                if (do_enq)
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (do_deq)
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                case ({do_enq, do_deq})
                    2'b10:   count[c] <= count[c] + 1'b1;
                    2'b01:   count[c] <= count[c] - 1'b1;
                    default: count[c] <= count[c];
                endcase
                if (bus.enq[c] && !full_n[c])
                    ovf[c] <= 1'b1;
            end
            if (deq_ok)
                rr_ptr <= (grant == V_CHW'(V_NCH-1)) ? '0 : grant + 1'b1;
        end
    end

    // Storage is not reset: reads are masked whenever the granted channel is empty.
    always_ff @(posedge clk) begin
        for (int c = 0; c < V_NCH; c++) begin
            if (!bus.clr && bus.enq[c] && full_n[c])
                mem[c][wr_ptr[c]] <= bus.d_in[c*V_P1WIDTH +: V_P1WIDTH];
        end
    end
endmodule
